// File: rtl/mc_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, functs, datapath select encodings
// and FSM state codes, also used by the ifu and the datapath top.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    NPC_PC4 = 3'b000,
    NPC_BEQ = 3'b001,
    NPC_J   = 3'b010,
    NPC_JR  = 3'b011
  } npc_sel_e;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,
    RD_RD = 2'b01,
    RD_RA = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    WD_ALU  = 2'b00,
    WD_MEM  = 2'b01,
    WD_PCP4 = 2'b10
  } wd_sel_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10
  } ext_op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_OR  = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } state_e;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in, control strobes out.
interface mc_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic [2:0]       NpcSel;
  logic             PcWr;
  logic             IrWr;
  logic             RegWr;
  logic [1:0]       RegDst;
  logic [1:0]       WdSel;
  logic [1:0]       ExtOp;
  logic             AluSrc;
  logic [1:0]       AluOp;
  logic             MemWr;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, funct, zero,
    output NpcSel, PcWr, IrWr, RegWr, RegDst, WdSel, ExtOp, AluSrc, AluOp,
           MemWr, illegal, state, retired
  );

  modport slave (
    output op, funct, zero,
    input  NpcSel, PcWr, IrWr, RegWr, RegDst, WdSel, ExtOp, AluSrc, AluOp,
           MemWr, illegal, state, retired
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational op/funct to instruction-class decoder for the multi-cycle FSM.
module mc_decode
  import mips_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       is_r,
  output logic       is_addu,
  output logic       is_subu,
  output logic       is_jr,
  output logic       is_ori,
  output logic       is_lui,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_jal,
  output logic       bad
);
  always_comb begin
    is_r    = (op == OP_RTYPE);
    is_addu = is_r && (funct == FN_ADDU);
    is_subu = is_r && (funct == FN_SUBU);
    is_jr   = is_r && (funct == FN_JR);
    is_ori  = (op == OP_ORI);
    is_lui  = (op == OP_LUI);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_beq  = (op == OP_BEQ);
    is_j    = (op == OP_J);
    is_jal  = (op == OP_JAL);
    bad     = !(is_addu || is_subu || is_jr || is_ori || is_lui || is_lw ||
                is_sw || is_beq || is_j || is_jal);
  end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DCD/EXE/MEM/WB with combinational
// strobes from state and IR fields, plus a retired-instruction counter.
module mc_ctrl
  import mips_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);
  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, bad;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  npc_sel_e npc_sel;
  reg_dst_e reg_dst;
  wd_sel_e  wd_sel;
  ext_op_e  ext_op;
  alu_op_e  alu_op;
  logic     pc_wr, ir_wr, reg_wr, mem_wr, alu_src, illegal;

  mc_decode u_decode (
    .op     (bus.op),
    .funct  (bus.funct),
    .is_r   (is_r),
    .is_addu(is_addu),
    .is_subu(is_subu),
    .is_jr  (is_jr),
    .is_ori (is_ori),
    .is_lui (is_lui),
    .is_lw  (is_lw),
    .is_sw  (is_sw),
    .is_beq (is_beq),
    .is_j   (is_j),
    .is_jal (is_jal),
    .bad    (bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DCD;
      S_DCD:   state_d = (bad || is_jr || is_j || is_jal) ? S_FETCH : S_EXE;
      S_EXE: begin
        if (is_beq)              state_d = S_FETCH;
        else if (is_lw || is_sw) state_d = S_MEM;
        else                     state_d = S_WB;
      end
      S_MEM:   state_d = is_lw ? S_WB : S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Every strobe is forced low while rst is held, since FETCH would otherwise raise IrWr.
  always_comb begin
    npc_sel = NPC_PC4;
    reg_dst = RD_RT;
    wd_sel  = WD_ALU;
    ext_op  = EXT_ZERO;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    reg_wr  = 1'b0;
    mem_wr  = 1'b0;
    illegal = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: ir_wr = 1'b1;
        S_DCD: begin
          if (bad) begin
            illegal = 1'b1;
            pc_wr   = 1'b1;
          end else if (is_jr) begin
            pc_wr   = 1'b1;
            npc_sel = NPC_JR;
          end else if (is_j || is_jal) begin
            pc_wr   = 1'b1;
            npc_sel = NPC_J;
            if (is_jal) begin
              reg_wr  = 1'b1;
              reg_dst = RD_RA;
              wd_sel  = WD_PCP4;
            end
          end
        end
        S_EXE: begin
          alu_src = is_ori || is_lui || is_lw || is_sw;
          if (is_lui)              ext_op = EXT_LUI;
          else if (is_lw || is_sw) ext_op = EXT_SIGN;
          if (is_subu || is_beq)   alu_op = ALU_SUB;
          else if (is_ori)         alu_op = ALU_OR;
          if (is_beq) begin
            pc_wr   = 1'b1;
            npc_sel = NPC_BEQ;
          end
        end
        S_MEM: begin
          if (is_sw) begin
            mem_wr = 1'b1;
            pc_wr  = 1'b1;
          end
        end
        S_WB: begin
          reg_wr  = is_addu || is_subu || is_ori || is_lui || is_lw;
          pc_wr   = reg_wr;
          reg_dst = is_r ? RD_RD : RD_RT;
          wd_sel  = is_lw ? WD_MEM : WD_ALU;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (pc_wr && !illegal) retired_d = retired_q + 1'b1;
  end

  assign bus.NpcSel  = npc_sel;
  assign bus.PcWr    = pc_wr;
  assign bus.IrWr    = ir_wr;
  assign bus.RegWr   = reg_wr;
  assign bus.RegDst  = reg_dst;
  assign bus.WdSel   = wd_sel;
  assign bus.ExtOp   = ext_op;
  assign bus.AluSrc  = alu_src;
  assign bus.AluOp   = alu_op;
  assign bus.MemWr   = mem_wr;
  assign bus.illegal = illegal;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed and random instructions against an
// instruction-class reference model of the expected per-cycle control trace.
module tb_mc_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(CNT_W)) bus();
  mc_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum {C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_BAD} cls_t;

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned ret_m = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] f);
    case (op)
      6'h00: begin
        if (f == 6'h21)      return C_ADDU;
        else if (f == 6'h23) return C_SUBU;
        else if (f == 6'h08) return C_JR;
        else                 return C_BAD;
      end
      6'h0D:   return C_ORI;
      6'h0F:   return C_LUI;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h02:   return C_J;
      6'h03:   return C_JAL;
      default: return C_BAD;
    endcase
  endfunction

  function automatic int n_cycles(input cls_t c);
    case (c)
      C_LW:                               return 5;
      C_ADDU, C_SUBU, C_ORI, C_LUI, C_SW: return 4;
      C_BEQ:                              return 3;
      default:                            return 2;
    endcase
  endfunction

  // State visited in cycle i: FETCH, DCD, EXE, then MEM for memory ops, WB last.
  function automatic int state_at(input cls_t c, input int i);
    if (i < 3) return i;
    if (i == 3 && (c == C_LW || c == C_SW)) return 3;
    return 4;
  endfunction

  function automatic bit writes_reg(input cls_t c);
    return c inside {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_JAL};
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
    cls_t c;
    int   n;
    int   st;
    bit   last;
    string nm;
    c  = classify(op, f);
    n  = n_cycles(c);
    nm = c.name();
    bus.op    = op;
    bus.funct = f;
    bus.zero  = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      last = (i == n - 1);
      st   = state_at(c, i);
      chk({nm, ".state"},   32'(bus.state),   32'(st));
      chk({nm, ".IrWr"},    32'(bus.IrWr),    32'(i == 0));
      chk({nm, ".PcWr"},    32'(bus.PcWr),    32'(last));
      chk({nm, ".RegWr"},   32'(bus.RegWr),   32'(last && writes_reg(c)));
      chk({nm, ".MemWr"},   32'(bus.MemWr),   32'(last && c == C_SW));
      chk({nm, ".illegal"}, 32'(bus.illegal), 32'(last && c == C_BAD));
      chk({nm, ".excl"},    32'(bus.MemWr & bus.RegWr), 32'd0);
      if (last) begin
        chk({nm, ".NpcSel"}, 32'(bus.NpcSel),
            (c == C_BEQ) ? 32'd1 : (c == C_J || c == C_JAL) ? 32'd2 : (c == C_JR) ? 32'd3 : 32'd0);
        if (writes_reg(c)) begin
          chk({nm, ".RegDst"}, 32'(bus.RegDst),
              (c == C_ADDU || c == C_SUBU) ? 32'd1 : (c == C_JAL) ? 32'd2 : 32'd0);
          chk({nm, ".WdSel"}, 32'(bus.WdSel),
              (c == C_LW) ? 32'd1 : (c == C_JAL) ? 32'd2 : 32'd0);
        end
      end
      if (st == 2) begin
        chk({nm, ".AluOp"}, 32'(bus.AluOp),
            (c == C_SUBU || c == C_BEQ) ? 32'd1 : (c == C_ORI) ? 32'd2 : 32'd0);
        chk({nm, ".AluSrc"}, 32'(bus.AluSrc), 32'(c inside {C_ORI, C_LUI, C_LW, C_SW}));
        if (c inside {C_ORI, C_LUI, C_LW, C_SW})
          chk({nm, ".ExtOp"}, 32'(bus.ExtOp),
              (c == C_LUI) ? 32'd2 : (c == C_ORI) ? 32'd0 : 32'd1);
      end
      @(posedge clk);
      #1;
    end
    if (c != C_BAD) ret_m = (ret_m + 1) % (1 << CNT_W);
    chk({nm, ".retired"}, 32'(bus.retired), 32'(ret_m));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".state"},   32'(bus.state),   32'd0);
    chk({tag, ".PcWr"},    32'(bus.PcWr),    32'd0);
    chk({tag, ".IrWr"},    32'(bus.IrWr),    32'd0);
    chk({tag, ".RegWr"},   32'(bus.RegWr),   32'd0);
    chk({tag, ".MemWr"},   32'(bus.MemWr),   32'd0);
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'd0);
    chk({tag, ".NpcSel"},  32'(bus.NpcSel),  32'd0);
    chk({tag, ".selects"}, 32'({bus.RegDst, bus.WdSel, bus.ExtOp, bus.AluSrc, bus.AluOp}), 32'd0);
    chk({tag, ".retired"}, 32'(bus.retired), 32'd0);
  endtask

  logic [5:0] leg_op [10];
  logic [5:0] leg_fn [10];

  initial begin
    leg_op = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    leg_fn = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    rst       = 1'b1;
    bus.op    = 6'h00;
    bus.funct = 6'h00;
    bus.zero  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;

    run_instr(6'h00, 6'h21, 1'b0);  // addu
    run_instr(6'h00, 6'h23, 1'b0);  // subu
    run_instr(6'h23, 6'h11, 1'b0);  // lw
    run_instr(6'h2B, 6'h05, 1'b0);  // sw
    run_instr(6'h04, 6'h00, 1'b1);  // beq taken
    run_instr(6'h04, 6'h00, 1'b0);  // beq not taken
    run_instr(6'h03, 6'h00, 1'b0);  // jal
    run_instr(6'h02, 6'h00, 1'b0);  // j
    run_instr(6'h00, 6'h08, 1'b0);  // jr
    run_instr(6'h0D, 6'h00, 1'b0);  // ori
    run_instr(6'h0F, 6'h00, 1'b0);  // lui
    run_instr(6'h3F, 6'h00, 1'b0);  // illegal op
    run_instr(6'h00, 6'h3F, 1'b0);  // illegal funct

    // Reset dropped on an addu while it sits in EXE.
    bus.op    = 6'h00;
    bus.funct = 6'h21;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midexe.state", 32'(bus.state), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midexe");
    @(posedge clk); #1;
    chk_reset_outputs("held");
    rst   = 1'b0;
    ret_m = 0;

    repeat (17) run_instr(6'h00, 6'h08, 1'b0);
    chk("wrap.retired", 32'(bus.retired), 32'd1);

    repeat (300) begin
      int unsigned r;
      r = $urandom_range(0, 11);
      if (r < 10)       run_instr(leg_op[r], leg_fn[r], 1'($urandom));
      else if (r == 10) run_instr(6'($urandom), 6'($urandom), 1'($urandom));
      else              run_instr(6'h00, 6'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the instruction-fetch unit and the rest of the MIPS datapath.
- Decodes the latched opcode and funct fields and steps each instruction through FETCH/DCD/EXE/MEM/WB.
- Drives the next-PC select, the PC and IR write strobes, and the register-file, ALU and data-memory controls.
- Sits beside the datapath top. Its only datapath feedback is the ALU zero flag.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- op  in  6  instr[31:26] from the IR.
- funct  in  6  instr[5:0] from the IR.
- zero  in  1  ALU zero flag, valid in EXE.
- NpcSel  out  3  next-PC select: 000 PC+4, 001 BEQ, 010 J/JAL, 011 JR.
- PcWr  out  1  PC write enable.
- IrWr  out  1  IR latch enable.
- RegWr  out  1  register-file write enable.
- RegDst  out  2  write register: 00 rt, 01 rd, 10 $31.
- WdSel  out  2  write data: 00 ALU, 01 memory, 10 pcp4.
- ExtOp  out  2  extender: 00 zero, 01 sign, 10 lui (imm<<16).
- AluSrc  out  1  0 selects rt, 1 selects extended immediate.
- AluOp  out  2  00 add, 01 sub, 10 or.
- MemWr  out  1  data-memory write enable.
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
- state  out  3  current state, for debug.
- retired  out  CNT_W  instructions completed since reset.

Behaviour:
- State encoding: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4. The state register is the only control state.
- Outputs are combinational from state, op and funct. retired is registered.
- Reset:
  - rst high forces state=FETCH and retired=0 immediately.
  - While rst is high, every write enable is 0: PcWr, IrWr, RegWr, MemWr. illegal=0.
  - Other outputs during reset: NpcSel=000, all other selects 0.
  - Reset mid-instruction abandons it with no further writes.
- FETCH: IrWr=1, then go to DCD. IR contents stay stable until the next FETCH.
- PC rule: PcWr is asserted exactly once per instruction, in that instruction's final cycle.
  - NpcSel=000 except for branches and jumps.
  - The npc logic computes from the unchanged PC of the current instruction.
- Instruction sequences (cycles include FETCH):
  - addu (op 0, funct 0x21) / subu (funct 0x23):
    - FETCH, DCD, EXE with AluSrc=0 and AluOp add/sub.
    - WB with RegDst=01, WdSel=00, RegWr=1, PcWr=1. Total 4 cycles.
  - jr (op 0, funct 0x08): DCD asserts PcWr=1, NpcSel=011. Total 2 cycles.
  - ori (0x0D): EXE uses ExtOp=00, AluSrc=1, AluOp=or. WB uses RegDst=00, RegWr=1, PcWr=1. Total 4 cycles.
  - lui (0x0F): as ori but ExtOp=10, AluOp=add. Total 4 cycles.
  - lw (0x23):
    - EXE uses ExtOp=01, AluSrc=1, add.
    - MEM performs the read.
    - WB uses WdSel=01, RegDst=00, RegWr=1, PcWr=1. Total 5 cycles.
  - sw (0x2B): EXE as lw. MEM asserts MemWr=1, PcWr=1. Total 4 cycles.
  - beq (0x04): EXE uses AluOp=sub, AluSrc=0, PcWr=1, NpcSel=001. The npc logic applies zero. Total 3 cycles.
  - j (0x02): DCD asserts PcWr=1, NpcSel=010. Total 2 cycles.
  - jal (0x03): DCD as j, plus RegWr=1, RegDst=10, WdSel=10. Total 2 cycles.
- Illegal op or funct:
  - In DCD, assert illegal=1 and PcWr=1 with NpcSel=000 (skip the instruction).
  - No RegWr or MemWr. Next state FETCH. retired does not increment.
- retired:
  - Increments by 1 on each clock edge where PcWr=1 and illegal=0.
  - Wraps modulo 2^CNT_W.
- Undefined state codes (5-7) return to FETCH on the next edge with no writes.
- MemWr and RegWr are never both 1 in the same cycle.

Decomposition:
- Shared package mips_defs holds:
  - opcode and funct constants;
  - NpcSel, RegDst, WdSel, ExtOp and AluOp encodings;
  - state encodings.
- The ifu and datapath top import the same NpcSel constants.
- One sub-module, mc_decode: combinational op/funct to instruction-class decoder. Its flags are is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, and bad.

Test Plan:
- Reset: rst high mid-EXE -> state=0, all write enables 0, retired=0 immediately. After release, the first cycle has IrWr=1.
- addu: state trace 0,1,2,4. RegWr=1 and PcWr=1 only in WB, with RegDst=01. retired 0->1.
- lw then sw: lw trace 0,1,2,3,4 with WdSel=01 in WB. sw trace 0,1,2,3 with MemWr=1 and PcWr=1 in MEM, RegWr=0 throughout.
- beq: zero=1 and zero=0 each give 3 cycles, PcWr=1 and NpcSel=001 in EXE. jal: 2 cycles, RegDst=10, WdSel=10, NpcSel=010.
- Illegal: op=0x3F, and separately op=0 with funct=0x3F -> illegal pulse in DCD, PcWr=1 with NpcSel=000, no RegWr/MemWr, retired unchanged.
- Counter wrap: CNT_W=4, run 17 jr instructions -> retired=1. PcWr is asserted exactly once per instruction.
